// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract unit. The operands are cut into STAGES equal slices.
// Each stage ripples one slice through a chain of full adders and registers
// the carry into the next slice. A single advance signal moves every stage at
// once, so downstream backpressure stalls the whole pipeline in place.
// WIDTH must be a multiple of STAGES.
module pipelined_ripple_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_i,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_o,
  output logic             ovf
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // Ripple one slice: returns {carry_into_msb, carry_out, sum[SW-1:0]}.
  function automatic logic [SW+1:0] add_slice(input logic [SW-1:0] x,
                                               input logic [SW-1:0] y,
                                               input logic          cin);
    logic [SW-1:0] sum;
    logic [1:0]    fa;
    logic          c;
    logic          c_msb;
    sum   = '0;
    c     = cin;
    c_msb = cin;
    for (int i = 0; i < SW; i++) begin
      c_msb  = c;
      fa     = full_add(x[i], y[i], c);
      sum[i] = fa[0];
      c      = fa[1];
    end
    return {c_msb, c, sum};
  endfunction

  // Per-stage state. Each stage keeps full-width copies of a / b_eff; only the
  // slices above the one already resolved are ever read downstream.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic              ovf_q, ovf_d;

  logic              adv_s;
  logic [WIDTH-1:0]  b_eff_s;
  logic              cin_eff_s;
  logic [SW+1:0]     slice_s;
  logic [STAGES-1:0] cmsb_s;

  // Advance when the output register is empty or being drained this cycle.
  always_comb begin
    adv_s = !valid_q[LAST] || out_ready;
  end

  assign in_ready = adv_s;

  // Subtraction is a + ~b + ~c_i, so condition b and the chain carry-in.
  always_comb begin
    if (sub) begin
      b_eff_s   = ~b;
      cin_eff_s = ~c_i;
    end else begin
      b_eff_s   = b;
      cin_eff_s = c_i;
    end
  end

  // Next-state for every stage: stage 0 resolves slice 0 from the inputs,
  // stage k resolves slice k from what stage k-1 holds.
  always_comb begin
    slice_s    = add_slice(a[SW-1:0], b_eff_s[SW-1:0], cin_eff_s);
    valid_d[0] = in_valid;
    a_d[0]     = a;
    b_d[0]     = b_eff_s;
    sum_d[0]   = '0;
    sum_d[0][SW-1:0] = slice_s[SW-1:0];
    carry_d[0] = slice_s[SW];
    cmsb_s     = '0;
    cmsb_s[0]  = slice_s[SW+1];
    for (int k = 1; k < STAGES; k++) begin
      slice_s    = add_slice(a_q[k-1][k*SW +: SW], b_q[k-1][k*SW +: SW], carry_q[k-1]);
      valid_d[k] = valid_q[k-1];
      a_d[k]     = a_q[k-1];
      b_d[k]     = b_q[k-1];
      sum_d[k]   = sum_q[k-1];
      sum_d[k][k*SW +: SW] = slice_s[SW-1:0];
      carry_d[k] = slice_s[SW];
      cmsb_s[k]  = slice_s[SW+1];
    end
    ovf_d = cmsb_s[LAST] ^ carry_d[LAST];
  end

  // Pipeline registers: clear on reset, shift together on advance, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (adv_s) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign s         = sum_q[LAST];
  assign c_o       = carry_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: a 16-bit/4-stage instance driven with
// directed, backpressured and random traffic, plus three 4-bit instances
// (1, 2 and 4 stages) streamed with every operand combination.
module tb_pipelined_ripple_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mode     = 0;
  int   cyc      = 0;

  // main 16-bit instance stimulus
  logic [15:0] ma, mb;
  logic        mci, msub, miv, mordy;
  // shared 4-bit instance stimulus
  logic [3:0]  xa, xb;
  logic        xci, xsub, xiv;

  logic        ir0, ov0, co0, ovf0;
  logic [15:0] s0;
  logic        ir1, ov1, co1, ovf1, ir2, ov2, co2, ovf2, ir3, ov3, co3, ovf3;
  logic [3:0]  s1, s2, s3;

  logic [15:0] a_v [4];
  logic [15:0] b_v [4];
  logic [15:0] s_v [4];
  logic        ci_v [4];
  logic        sub_v [4];
  logic        iv_v [4];
  logic        ordy_v [4];
  logic        ir_v [4];
  logic        ov_v [4];
  logic        co_v [4];
  logic        ovf_v [4];
  logic [17:0] exp_q [4][$];

  initial forever #5 clk = ~clk;

  pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(miv), .in_ready(ir0), .a(ma), .b(mb),
    .c_i(mci), .sub(msub), .out_valid(ov0), .out_ready(mordy), .s(s0), .c_o(co0), .ovf(ovf0));
  pipelined_ripple_adder #(.WIDTH(4), .STAGES(1)) u_w4s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(xiv), .in_ready(ir1), .a(xa), .b(xb),
    .c_i(xci), .sub(xsub), .out_valid(ov1), .out_ready(1'b1), .s(s1), .c_o(co1), .ovf(ovf1));
  pipelined_ripple_adder #(.WIDTH(4), .STAGES(2)) u_w4s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(xiv), .in_ready(ir2), .a(xa), .b(xb),
    .c_i(xci), .sub(xsub), .out_valid(ov2), .out_ready(1'b1), .s(s2), .c_o(co2), .ovf(ovf2));
  pipelined_ripple_adder #(.WIDTH(4), .STAGES(4)) u_w4s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(xiv), .in_ready(ir3), .a(xa), .b(xb),
    .c_i(xci), .sub(xsub), .out_valid(ov3), .out_ready(1'b1), .s(s3), .c_o(co3), .ovf(ovf3));

  // Gather every instance into index-able views for the single compare process.
  always_comb begin
    a_v[0] = ma;  b_v[0] = mb;  ci_v[0] = mci; sub_v[0] = msub; iv_v[0] = miv; ordy_v[0] = mordy;
    ir_v[0] = ir0; ov_v[0] = ov0; s_v[0] = s0; co_v[0] = co0; ovf_v[0] = ovf0;
    for (int d = 1; d < 4; d++) begin
      a_v[d] = {12'd0, xa}; b_v[d] = {12'd0, xb}; ci_v[d] = xci; sub_v[d] = xsub;
      iv_v[d] = xiv; ordy_v[d] = 1'b1;
    end
    ir_v[1] = ir1; ov_v[1] = ov1; s_v[1] = {12'd0, s1}; co_v[1] = co1; ovf_v[1] = ovf1;
    ir_v[2] = ir2; ov_v[2] = ov2; s_v[2] = {12'd0, s2}; co_v[2] = co2; ovf_v[2] = ovf2;
    ir_v[3] = ir3; ov_v[3] = ov3; s_v[3] = {12'd0, s3}; co_v[3] = co3; ovf_v[3] = ovf3;
  end

  // Reference: plain integer arithmetic, returns {ovf, c_o, s[15:0]}.
  function automatic logic [17:0] model(input int w, input int av, input int bv,
                                        input int ci, input int sb);
    int full, half, sa, sbv, u, r, sm;
    logic co, ov;
    logic [17:0] res;
    full = 1 << w;
    half = 1 << (w - 1);
    sa   = (av >= half) ? av - full : av;
    sbv  = (bv >= half) ? bv - full : bv;
    if (sb != 0) begin
      u = av - bv - ci;  r = sa - sbv - ci;  co = (u >= 0);
    end else begin
      u = av + bv + ci;  r = sa + sbv + ci;  co = (u >= full);
    end
    ov  = (r < -half) || (r >= half);
    sm  = u & (full - 1);
    res = '0;
    res[15:0] = sm[15:0];
    res[16]   = co;
    res[17]   = ov;
    return res;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Scoreboard: every cycle, check in_ready and any valid output, then log
  // the accepted operand. Sampled at negedge, i.e. the values seen by the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 4; d++) exp_q[d].delete();
    end else begin
      for (int d = 0; d < 4; d++) begin
        int w;
        logic [17:0] got;
        w = (d == 0) ? 16 : 4;
        n_checks++;
        if (ir_v[d] !== (!ov_v[d] || ordy_v[d])) begin
          n_fail++;
          $display("FAIL in_ready dut%0d: got %b expected %b", d, ir_v[d], !ov_v[d] || ordy_v[d]);
        end
        if (ov_v[d] === 1'b1) begin
          got = {ovf_v[d], co_v[d], s_v[d]};
          n_checks++;
          if (exp_q[d].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output dut%0d: got %h expected none", d, got);
          end else begin
            if (got !== exp_q[d][0]) begin
              n_fail++;
              $display("FAIL result dut%0d: got %h expected %h", d, got, exp_q[d][0]);
            end
            if (ordy_v[d]) void'(exp_q[d].pop_front());
          end
        end
        if (iv_v[d] && ir_v[d] === 1'b1)
          exp_q[d].push_back(model(w, int'(a_v[d]), int'(b_v[d]), int'(ci_v[d]), int'(sub_v[d])));
      end
    end
  end

  // out_ready driver: always on, the 1,0,0 pattern, or random.
  initial begin
    mordy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        1: begin mordy = (cyc % 3 == 0); cyc++; end
        2: mordy = 1'($urandom_range(0, 1));
        default: mordy = 1'b1;
      endcase
    end
  end

  // Present one operand and hold it until the block takes it.
  task automatic send16(input logic [15:0] ta, input logic [15:0] tb,
                        input logic tci, input logic tsub);
    int n = 0;
    logic acc;
    ma = ta; mb = tb; mci = tci; msub = tsub; miv = 1'b1;
    do begin
      @(negedge clk); acc = ir0;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    miv = 1'b0;
  endtask

  // One isolated operand: check latency and literal result.
  task automatic single(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                        input logic tsub, input logic [17:0] ex, input string nm);
    int n = 0;
    send16(ta, tb, tci, tsub);
    while (ov0 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check({nm, "_latency"}, n, 32'd3);
    check({nm, "_value"}, {14'd0, ovf0, co0, s0}, {14'd0, ex});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0 ||
            exp_q[3].size() != 0 || ov0 || ov1 || ov2 || ov3) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("drain", n < 500, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    ma = '0; mb = '0; mci = 1'b0; msub = 1'b0; miv = 1'b0;
    xa = '0; xb = '0; xci = 1'b0; xsub = 1'b0; xiv = 1'b0;

    // pin the reference with hand-worked values
    check("model_ffff_p1", model(16, 'hFFFF, 1, 0, 0), 18'h10000);
    check("model_7fff_p1", model(16, 'h7FFF, 1, 0, 0), 18'h28000);
    check("model_1234_4321_c", model(16, 'h1234, 'h4321, 1, 0), 18'h05556);
    check("model_5_m7", model(16, 5, 7, 0, 1), 18'h0FFFE);
    check("model_8000_m1", model(16, 'h8000, 1, 0, 1), 18'h37FFF);
    check("model_w4_sub_borrow", model(4, 0, 0, 1, 1), 18'h0000F);

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", ov0, 32'd0);
    check("reset_s", s0, 32'd0);
    check("reset_c_o", co0, 32'd0);
    check("reset_ovf", ovf0, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // directed add / subtract corners
    single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000, "add_wrap");
    single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000, "add_ovf");
    single(16'h1234, 16'h4321, 1'b1, 1'b0, 18'h05556, "add_cin");
    single(16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE, "sub_neg");
    single(16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF, "sub_ovf");

    // streaming with 1,0,0 backpressure pattern
    mode = 1; cyc = 0;
    for (int i = 0; i < 10; i++)
      send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
    mode = 0;

    // every 4-bit operand combination into the 1/2/4-stage instances
    for (int i = 0; i < 1024; i++) begin
      {xsub, xci, xa, xb} = i[9:0];
      xiv = 1'b1;
      @(posedge clk); #1;
    end
    xiv = 1'b0;
    drain();

    // random traffic with random gaps and random backpressure
    mode = 2;
    for (int i = 0; i < 400; i++) begin
      miv  = 1'($urandom_range(0, 1));
      ma   = 16'($urandom);
      mb   = 16'($urandom);
      mci  = 1'($urandom_range(0, 1));
      msub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    miv = 1'b0;
    mode = 0;
    drain();

    // reset with three items in flight
    for (int i = 0; i < 3; i++) begin
      ma = 16'h0100 + 16'(i); mb = 16'h0011; mci = 1'b0; msub = 1'b0; miv = 1'b1;
      @(posedge clk); #1;
    end
    miv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", ov0, 32'd0);
    check("midreset_s", s0, 32'd0);
    check("midreset_c_o", co0, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    single(16'h0001, 16'h0001, 1'b0, 1'b0, 18'h00002, "after_reset");
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_output", ov0, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
Parametrised, pipelined add/subtract unit built on the team's full-adder carry chain. The WIDTH-bit operands are split into STAGES equal slices. Each pipeline stage resolves one slice and registers the inter-slice carry, so the critical path is one slice rather than the full width. A valid/ready handshake on both sides lets the block sit between streaming datapath blocks and absorb downstream backpressure.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages and slices; each slice is WIDTH/STAGES bits; STAGES >= 1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  operands present this cycle
in_ready  out  1  block accepts operands this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
c_i  in  1  carry-in in add mode; borrow-in in subtract mode
sub  in  1  0 = a+b+c_i; 1 = a-b-c_i
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
s  out  WIDTH  sum or difference
c_o  out  1  carry-out of MSB (subtract: 1 = no borrow)
ovf  out  1  two's-complement overflow

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0; out_valid = 0; s = 0; c_o = 0; ovf = 0. Datapath registers clear to 0.
- Operand conditioning at acceptance:
  - b_eff = sub ? ~b : b.
  - Chain carry-in = sub ? ~c_i : c_i.
  - Subtract therefore computes a + ~b + ~c_i = a - b - c_i mod 2^WIDTH.
- Pipeline: stage k (k = 0..STAGES-1) holds:
  - valid bit;
  - sum slices 0..k;
  - registered carry out of slice k;
  - carry into slice k's MSB;
  - not-yet-used slices of a and b_eff.
- Slice k is a ripple of WIDTH/STAGES full adders, computed combinationally between stage k-1 and stage k. Slice 0 is computed from the inputs directly.
- The last stage is the output register: s, c_o, out_valid.
- ovf = (carry into MSB) XOR c_o, computed from the last slice.
- Advance signal: adv = !out_valid || out_ready.
  - in_ready = adv; this is combinational and is the only combinational in-to-out path.
  - When adv = 1, every stage shifts forward one position. Stage 0 loads the new operands if in_valid, otherwise a bubble (valid = 0).
  - When adv = 0, all stages hold. Inputs are ignored and in_ready = 0.
- Handshake:
  - A transfer occurs on an edge where in_valid & in_ready (input side) or out_valid & out_ready (output side).
  - in_valid may drop without waiting for in_ready.
  - s, c_o and ovf are stable while out_valid = 1 and out_ready = 0.
- Latency: an operand accepted at edge E0 appears with out_valid = 1 after edge E0 + STAGES - 1. STAGES = 1 therefore gives a single registered full-width adder.
- Throughput: one result per cycle with out_ready held high. No bubbles are inserted by the block.
- Ordering: results leave in acceptance order; there is no reordering or dropping.
- Full pipeline with stall: at most STAGES results are in flight. in_ready stays low until out_ready rises; the accepted item then enters on that same edge.
- Simultaneous events: with out_valid & out_ready & in_valid all high on one edge, the output transfers and the new item is accepted on the same edge.
- Wrap-around: s is the result mod 2^WIDTH; carry beyond the MSB appears only on c_o.
- Reset mid-operation: all in-flight items are discarded and no partial result is emitted. The first item accepted after reset release appears after the normal latency.

Test Plan:
1. WIDTH=16, STAGES=4, add: a=0xFFFF, b=0x0001, c_i=0 -> after 4 edges: s=0x0000, c_o=1, ovf=0.
2. Add: a=0x7FFF, b=0x0001, c_i=0 -> s=0x8000, c_o=0, ovf=1. Then a=0x1234, b=0x4321, c_i=1 -> s=0x5556, c_o=0, ovf=0.
3. Subtract: a=0x0005, b=0x0007, c_i=0 -> s=0xFFFE, c_o=0, ovf=0. Then a=0x8000, b=0x0001, c_i=0 -> s=0x7FFF, c_o=1, ovf=1.
4. Streaming with backpressure: 10 back-to-back operands, out_ready toggled 1,0,0,1,... -> in_ready low exactly when out_valid & !out_ready; all 10 results arrive in order with values held during stalls.
5. Exhaustive, WIDTH=4, STAGES=2: all a, b, c_i, sub (1024 vectors) streamed -> every s, c_o, ovf matches a reference model; also rerun with STAGES=1 and STAGES=4.
6. Reset mid-stream: assert rst_n low with 3 items in flight -> out_valid=0, s=0 immediately. After release, a=0x0001, b=0x0001 -> single result s=0x0002 after 4 edges, no stale outputs.
